// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared opcodes, PC-source encodings and sequencer state for the RISC16 control unit.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package risc16_ctrl_pkg;

    // Opcode field [15:12]
    localparam logic [3:0] OP_LW  = 4'b0100;
    localparam logic [3:0] OP_LM  = 4'b0110;
    localparam logic [3:0] OP_SM  = 4'b0111;
    localparam logic [3:0] OP_BEQ = 4'b1000;
    localparam logic [3:0] OP_BLT = 4'b1001;
    localparam logic [3:0] OP_BLE = 4'b1010;
    localparam logic [3:0] OP_JAL = 4'b1100;
    localparam logic [3:0] OP_JLR = 4'b1101;
    localparam logic [3:0] OP_JRI = 4'b1111;

    // PC-source mux select
    localparam logic [1:0] PCSEL_SEQ  = 2'b00;  // PC+1
    localparam logic [1:0] PCSEL_EXBR = 2'b01;  // EX branch / JAL target
    localparam logic [1:0] PCSEL_JLR  = 2'b10;  // JLR target from RR
    localparam logic [1:0] PCSEL_JRI  = 2'b11;  // JRI target from EX

    // LM/SM micro-sequencer state
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEQ  = 1'b1
    } seq_state_t;

    // Conditional branches resolved by the EX comparator
    function automatic logic is_branch(input logic [3:0] op);
        return (op == OP_BEQ) || (op == OP_BLT) || (op == OP_BLE);
    endfunction

    // Unconditional jumps of any flavour
    function automatic logic is_jump(input logic [3:0] op);
        return (op == OP_JAL) || (op == OP_JLR) || (op == OP_JRI);
    endfunction

    // Multi-register load/store
    function automatic logic is_lmsm(input logic [3:0] op);
        return (op == OP_LM) || (op == OP_SM);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle of stage instruction registers in and pipeline controls out.
// Latency: wires only.
// Backpressure: none; controls are the stall mechanism for the pipeline itself.
interface pipe_hazard_ctrl_if #(
    parameter int IW   = 16,
    parameter int NREG = 8
);
    localparam int IDXW = $clog2(NREG);

    logic [IW-1:0]   if_id_ir;
    logic [IW-1:0]   id_rr_ir;
    logic [IW-1:0]   rr_ex_ir;
    logic [IW-1:0]   ex_mem_ir;
    logic            br_taken;

    logic            pc_en;
    logic            if_id_en;
    logic            id_rr_en;
    logic            if_id_clr;
    logic            id_rr_clr;
    logic            rr_ex_clr;
    logic            ex_mem_clr;
    logic [1:0]      pc_sel;
    logic            seq_busy;
    logic [IDXW-1:0] seq_idx;
    logic [IDXW:0]   seq_ofs;
    logic            seq_first;
    logic            seq_last;

    // Datapath side: supplies IRs, consumes controls
    modport master (
        output if_id_ir, id_rr_ir, rr_ex_ir, ex_mem_ir, br_taken,
        input  pc_en, if_id_en, id_rr_en, if_id_clr, id_rr_clr, rr_ex_clr,
               ex_mem_clr, pc_sel, seq_busy, seq_idx, seq_ofs, seq_first, seq_last
    );

    // Control unit side
    modport slave (
        input  if_id_ir, id_rr_ir, rr_ex_ir, ex_mem_ir, br_taken,
        output pc_en, if_id_en, id_rr_en, if_id_clr, id_rr_clr, rr_ex_clr,
               ex_mem_clr, pc_sel, seq_busy, seq_idx, seq_ofs, seq_first, seq_last
    );

endinterface

// File: rtl/pipe_hazard_ctrl_lsb_first_enc.sv
// Lowest-set-bit priority encoder used to pick the next LM/SM register.
// Latency: combinational.
// Backpressure: n/a; valid low means the mask is empty and idx is 0.
module lsb_first_enc #(
    parameter int N = 8,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] mask,
    output logic [W-1:0] idx,
    output logic         valid
);

    // Scan from the top so the lowest set bit is the last one written
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx = W'(i);
            end
        end
    end

    assign valid = |mask;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard/redirect control with LM/SM micro-sequencer for the 16-bit 5-stage core.
// Latency: controls are combinational from the IRs and sequencer state; sequencer advances per clk.
// Backpressure: front end is frozen for load-use (1 cycle) and for k-1 cycles of a k-register LM/SM.
module pipe_hazard_ctrl
    import risc16_ctrl_pkg::*;
#(
    parameter int IW   = 16,
    parameter int NREG = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    pipe_hazard_ctrl_if.slave hz
);

    localparam int IDXW = $clog2(NREG);
    localparam logic [IDXW:0] OFS_ONE = (IDXW + 1)'(1);

    // Sequencer state
    seq_state_t      r_state;
    seq_state_t      w_state_nxt;
    logic [NREG-1:0] r_rem;
    logic [NREG-1:0] w_rem_nxt;
    logic [IDXW:0]   r_ofs;
    logic [IDXW:0]   w_ofs_nxt;

    // Decoded IR fields
    logic [3:0] w_ex_op;
    logic [3:0] w_rr_op;
    logic [2:0] w_ex_ra;
    logic [2:0] w_rr_ra;
    logic [2:0] w_rr_rb;
    logic [NREG-1:0] w_rr_mask;

    assign w_ex_op   = hz.rr_ex_ir[IW-1 -: 4];
    assign w_ex_ra   = hz.rr_ex_ir[IW-5 -: 3];
    assign w_rr_op   = hz.id_rr_ir[IW-1 -: 4];
    assign w_rr_ra   = hz.id_rr_ir[IW-5 -: 3];
    assign w_rr_rb   = hz.id_rr_ir[IW-8 -: 3];
    assign w_rr_mask = hz.id_rr_ir[NREG-1:0];

    // IF/ID and EX/MEM IRs feed no rule yet; keep them visible for future hazards
    logic w_unused_ir;
    assign w_unused_ir = ^{hz.if_id_ir, hz.ex_mem_ir};

    // Hazard detection
    logic w_ex_redirect;
    logic w_load_use;
    logic w_rr_lmsm;
    logic w_in_seq;

    assign w_ex_redirect = (is_branch(w_ex_op) && hz.br_taken)
                         || (w_ex_op == OP_JAL) || (w_ex_op == OP_JRI);
    // Conservative: any IR whose ra/rb field matches counts, whether or not it reads it
    assign w_load_use    = (w_ex_op == OP_LW) && (hz.id_rr_ir != '0) && (w_rr_op != OP_JAL)
                         && ((w_ex_ra == w_rr_ra) || (w_ex_ra == w_rr_rb));
    assign w_rr_lmsm     = is_lmsm(w_rr_op);
    assign w_in_seq      = (r_state == ST_SEQ);

    // Working mask: fresh from the IR on entry, the leftover bits once sequencing
    logic [NREG-1:0] w_work_mask;
    logic [IDXW-1:0] w_enc_idx;
    logic            w_enc_vld;
    logic [NREG-1:0] w_pick_bit;
    logic [NREG-1:0] w_rem;
    logic            w_last;
    logic [IDXW:0]   w_ofs_cur;
    logic            w_seq_act;

    assign w_work_mask = w_in_seq ? r_rem : w_rr_mask;

    lsb_first_enc #(.N(NREG)) u_enc (
        .mask  (w_work_mask),
        .idx   (w_enc_idx),
        .valid (w_enc_vld)
    );

    // One-hot of the register transferred this cycle
    always_comb begin
        w_pick_bit = '0;
        w_pick_bit[w_enc_idx] = 1'b1;
    end

    assign w_rem     = w_work_mask & ~w_pick_bit;
    assign w_last    = (w_rem == '0);
    assign w_ofs_cur = w_in_seq ? r_ofs : '0;
    assign w_seq_act = !w_ex_redirect && !w_load_use
                     && (w_in_seq || (w_rr_lmsm && w_enc_vld));

    // Control outputs
    logic            w_pc_en;
    logic            w_if_id_en;
    logic            w_id_rr_en;
    logic            w_if_id_clr;
    logic            w_id_rr_clr;
    logic            w_rr_ex_clr;
    logic            w_ex_mem_clr;
    logic [1:0]      w_pc_sel;
    logic            w_seq_busy;
    logic [IDXW-1:0] w_seq_idx;
    logic [IDXW:0]   w_seq_ofs;
    logic            w_seq_first;
    logic            w_seq_last;

    // Sequencer state register; reset aborts any transfer in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_rem   <= '0;
            r_ofs   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_rem   <= w_rem_nxt;
            r_ofs   <= w_ofs_nxt;
        end
    end

    // Priority resolution: EX redirect > load-use > LM/SM > RR redirect > default
    always_comb begin
        w_state_nxt  = r_state;
        w_rem_nxt    = r_rem;
        w_ofs_nxt    = r_ofs;
        w_pc_en      = 1'b1;
        w_if_id_en   = 1'b1;
        w_id_rr_en   = 1'b1;
        w_if_id_clr  = 1'b0;
        w_id_rr_clr  = 1'b0;
        w_rr_ex_clr  = 1'b0;
        w_ex_mem_clr = 1'b0;
        w_pc_sel     = PCSEL_SEQ;
        w_seq_busy   = 1'b0;
        w_seq_idx    = '0;
        w_seq_ofs    = '0;
        w_seq_first  = 1'b0;
        w_seq_last   = 1'b0;

        if (w_ex_redirect) begin
            w_pc_sel    = (w_ex_op == OP_JRI) ? PCSEL_JRI : PCSEL_EXBR;
            w_if_id_clr = 1'b1;
            w_id_rr_clr = 1'b1;
            w_rr_ex_clr = 1'b1;
            w_state_nxt = ST_IDLE;
            w_rem_nxt   = '0;
            w_ofs_nxt   = '0;
        end else if (w_load_use) begin
            // Bubble into EX; sequencer holds so an LM/SM starts after the stall
            w_pc_en     = 1'b0;
            w_if_id_en  = 1'b0;
            w_id_rr_en  = 1'b0;
            w_rr_ex_clr = 1'b1;
        end else if (w_seq_act) begin
            w_seq_busy  = 1'b1;
            w_seq_idx   = w_enc_idx;
            w_seq_ofs   = w_ofs_cur;
            w_seq_first = !w_in_seq;
            w_seq_last  = w_last;
            if (w_last) begin
                w_state_nxt = ST_IDLE;
                w_rem_nxt   = '0;
                w_ofs_nxt   = '0;
            end else begin
                // Hold the front end; the LM/SM re-enters EX as the next micro-op
                w_pc_en     = 1'b0;
                w_if_id_en  = 1'b0;
                w_id_rr_en  = 1'b0;
                w_state_nxt = ST_SEQ;
                w_rem_nxt   = w_rem;
                w_ofs_nxt   = w_ofs_cur + OFS_ONE;
            end
        end else if (w_rr_lmsm) begin
            // Empty mask: squash to a NOP without stalling
            w_id_rr_clr = 1'b1;
        end else if (w_rr_op == OP_JLR) begin
            w_pc_sel    = PCSEL_JLR;
            w_if_id_clr = 1'b1;
            w_id_rr_clr = 1'b1;
        end

        // Reset freezes the pipe and flushes every stage
        if (!rst_n) begin
            w_pc_en      = 1'b0;
            w_if_id_en   = 1'b0;
            w_id_rr_en   = 1'b0;
            w_if_id_clr  = 1'b1;
            w_id_rr_clr  = 1'b1;
            w_rr_ex_clr  = 1'b1;
            w_ex_mem_clr = 1'b1;
            w_pc_sel     = PCSEL_SEQ;
            w_seq_busy   = 1'b0;
            w_seq_idx    = '0;
            w_seq_ofs    = '0;
            w_seq_first  = 1'b0;
            w_seq_last   = 1'b0;
        end
    end

    assign hz.pc_en      = w_pc_en;
    assign hz.if_id_en   = w_if_id_en;
    assign hz.id_rr_en   = w_id_rr_en;
    assign hz.if_id_clr  = w_if_id_clr;
    assign hz.id_rr_clr  = w_id_rr_clr;
    assign hz.rr_ex_clr  = w_rr_ex_clr;
    assign hz.ex_mem_clr = w_ex_mem_clr;
    assign hz.pc_sel     = w_pc_sel;
    assign hz.seq_busy   = w_seq_busy;
    assign hz.seq_idx    = w_seq_idx;
    assign hz.seq_ofs    = w_seq_ofs;
    assign hz.seq_first  = w_seq_first;
    assign hz.seq_last   = w_seq_last;

endmodule
